// File: rtl/udp_payload_packer.sv
// Ping-pong sample packer feeding the GMII UDP transmitter: fills two banks of
// 32-bit words and streams each closed bank as one frame. Define PKT_SEQ_HDR_EN
// to prefix every frame with a 4-byte big-endian sequence number.
module udp_payload_packer #(
  parameter int PKT_WORDS = 256,
  parameter int ADDR_W    = 8,
  parameter int IFG_WAIT  = 16
) (
  input  logic        clk125m,
  input  logic        reset_n,
  input  logic        sample_valid,
  input  logic [31:0] sample_data,
  input  logic        flush,
  output logic        tx_en_pulse,
  output logic [15:0] data_length,
  input  logic        payload_req_i,
  output logic [7:0]  payload_dat_o,
  input  logic        tx_done,
  output logic        busy,
  output logic        overflow,
  output logic [15:0] drop_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = ADDR_W + 1;
  localparam logic [CW-1:0] PKT_CNT  = CW'(PKT_WORDS);
  localparam logic [15:0]   GAP_LAST = 16'(IFG_WAIT - 1);
`ifdef PKT_SEQ_HDR_EN
  localparam logic [15:0] HDR = 16'd4;
`else
  localparam logic [15:0] HDR = 16'd0;
`endif

  typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;

  state_t         state_q, state_d;
  logic [1:0]     full_q, full_d;
  logic [CW-1:0]  count_q [2];
  logic [CW-1:0]  count_d [2];
  logic           wbank_q, wbank_d;
  logic           rbank_q, rbank_d;
  logic [15:0]    ptr_q, ptr_d;
  logic [15:0]    gap_q, gap_d;
  logic [15:0]    len_q, len_d;
  logic           tx_en_q, tx_en_d;
  logic           busy_q, busy_d;
  logic           ovf_q, ovf_d;
  logic [15:0]    drop_q, drop_d;
`ifdef PKT_SEQ_HDR_EN
  logic [31:0]    seq_q, seq_d;
`endif

  logic [31:0]    mem_q [2][DEPTH];
  logic           wr_en;
  logic           drop;
  logic           release_bank;
  logic [CW-1:0]  cnt_next;
  logic [15:0]    byte_off;
  logic [31:0]    rd_word;
  logic [7:0]     rd_byte;

  // Write side only ever sees full flags as registered, so a same-cycle release can't rescue a sample.
  assign wr_en        = sample_valid && !full_q[wbank_q];
  assign drop         = sample_valid && full_q[wbank_q];
  assign release_bank = (state_q == SEND) && tx_done;
  assign cnt_next     = count_q[wbank_q] + 1'b1;

  always_comb begin
    full_d  = full_q;
    count_d = count_q;
    wbank_d = wbank_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    if (release_bank) begin
      full_d[rbank_q]  = 1'b0;
      count_d[rbank_q] = '0;
    end
    if (wr_en) begin
      count_d[wbank_q] = cnt_next;
      if (cnt_next == PKT_CNT || flush) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
      end
    end else if (flush && !full_q[wbank_q] && count_q[wbank_q] != '0) begin
      full_d[wbank_q] = 1'b1;
      wbank_d         = ~wbank_q;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    gap_d   = gap_q;
    rbank_d = rbank_q;
`ifdef PKT_SEQ_HDR_EN
    seq_d   = seq_q;
`endif
    case (state_q)
      IDLE: begin
        if (full_q[rbank_q]) begin
          len_d   = HDR + (16'(count_q[rbank_q]) << 2);
          ptr_d   = '0;
          state_d = START;
        end
      end
      START: state_d = SEND;
      SEND: begin
        if (payload_req_i && ptr_q < len_q) ptr_d = ptr_q + 16'd1;
        if (tx_done) begin
          rbank_d = ~rbank_q;
`ifdef PKT_SEQ_HDR_EN
          seq_d   = seq_q + 32'd1;
`endif
          gap_d   = GAP_LAST;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase
    tx_en_d = (state_d == START);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk125m or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      full_q     <= '0;
      count_q[0] <= '0;
      count_q[1] <= '0;
      wbank_q    <= 1'b0;
      rbank_q    <= 1'b0;
      ptr_q      <= '0;
      gap_q      <= '0;
      len_q      <= '0;
      tx_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      drop_q     <= '0;
`ifdef PKT_SEQ_HDR_EN
      seq_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      full_q     <= full_d;
      count_q[0] <= count_d[0];
      count_q[1] <= count_d[1];
      wbank_q    <= wbank_d;
      rbank_q    <= rbank_d;
      ptr_q      <= ptr_d;
      gap_q      <= gap_d;
      len_q      <= len_d;
      tx_en_q    <= tx_en_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
`ifdef PKT_SEQ_HDR_EN
      seq_q      <= seq_d;
`endif
    end
  end

  always_ff @(posedge clk125m) begin
    if (wr_en) mem_q[wbank_q][count_q[wbank_q][ADDR_W-1:0]] <= sample_data;
  end

  // Register-file banks give an asynchronous read, so the byte is ready the cycle it is requested.
  assign byte_off = ptr_q - HDR;
  assign rd_word  = mem_q[rbank_q][ADDR_W'(byte_off >> 2)];

  always_comb begin
    case (byte_off[1:0])
      2'd0:    rd_byte = rd_word[31:24];
      2'd1:    rd_byte = rd_word[23:16];
      2'd2:    rd_byte = rd_word[15:8];
      default: rd_byte = rd_word[7:0];
    endcase
  end

  always_comb begin
    payload_dat_o = 8'h00;
    if (state_q == SEND && ptr_q < len_q) begin
      payload_dat_o = rd_byte;
`ifdef PKT_SEQ_HDR_EN
      if (ptr_q < HDR) begin
        case (ptr_q[1:0])
          2'd0:    payload_dat_o = seq_q[31:24];
          2'd1:    payload_dat_o = seq_q[23:16];
          2'd2:    payload_dat_o = seq_q[15:8];
          default: payload_dat_o = seq_q[7:0];
        endcase
      end
`endif
    end
  end

  assign tx_en_pulse = tx_en_q;
  assign data_length = len_q;
  assign busy        = busy_q;
  assign overflow    = ovf_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_udp_payload_packer.sv
// Directed bench for udp_payload_packer at PKT_WORDS=4; expectations follow
// PKT_SEQ_HDR_EN so the same bench covers both builds.
module tb_udp_payload_packer;

  localparam int PKT_WORDS = 4;
  localparam int ADDR_W    = 2;
  localparam int IFG_WAIT  = 16;
`ifdef PKT_SEQ_HDR_EN
  localparam int HDR = 4;
`else
  localparam int HDR = 0;
`endif

  logic        clk125m = 1'b0;
  logic        reset_n;
  logic        sample_valid;
  logic [31:0] sample_data;
  logic        flush;
  logic        tx_en_pulse;
  logic [15:0] data_length;
  logic        payload_req_i;
  logic [7:0]  payload_dat_o;
  logic        tx_done;
  logic        busy;
  logic        overflow;
  logic [15:0] drop_cnt;

  int nVec  = 0;
  int nFail = 0;
  logic [31:0] frameWords [0:3];

  typedef struct {
    logic        sv;
    logic [31:0] sd;
    logic        fl;
    logic        expTx;
    logic        expBusy;
    logic [15:0] expLen;
  } vec_t;
  vec_t vecs [8];

  udp_payload_packer #(
    .PKT_WORDS(PKT_WORDS),
    .ADDR_W   (ADDR_W),
    .IFG_WAIT (IFG_WAIT)
  ) dut (
    .clk125m      (clk125m),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .flush        (flush),
    .tx_en_pulse  (tx_en_pulse),
    .data_length  (data_length),
    .payload_req_i(payload_req_i),
    .payload_dat_o(payload_dat_o),
    .tx_done      (tx_done),
    .busy         (busy),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt)
  );

  always #4 clk125m = ~clk125m;

  // Inputs change on the falling edge and outputs are observed 1 ns later, mid-cycle.
  task automatic applyStimulus(input logic sv, input logic [31:0] sd, input logic fl,
                               input logic req, input logic done);
    @(negedge clk125m);
    sample_valid  = sv;
    sample_data   = sd;
    flush         = fl;
    payload_req_i = req;
    tx_done       = done;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVec++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] expByte(input int k, input int len, input logic [31:0] seq);
    logic [31:0] t;
    int j;
    if (k >= len) return 8'h00;
    if (k < HDR) begin
      t = seq >> (8 * (3 - k));
      return t[7:0];
    end
    j = k - HDR;
    t = frameWords[j / 4] >> (8 * (3 - (j % 4)));
    return t[7:0];
  endfunction

  task automatic sendPayload(input string name, input int nWords, input logic [31:0] seq, input int extra);
    int len;
    len = HDR + 4 * nWords;
    for (int k = 0; k < len + extra; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("%s byte %0d", name, k), {24'h0, payload_dat_o}, {24'h0, expByte(k, len, seq)});
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic waitStart(input string name, input int expCycles, input int expLen);
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      cyc++;
      if (tx_en_pulse) seen = 1'b1;
    end
    if (!seen) begin
      nVec++;
      nFail++;
      $display("[TB] FAIL %s start timeout: got no tx_en_pulse, expected one within 60 cycles", name);
    end else begin
      checkOutput({name, " latency"}, cyc, expCycles);
      checkOutput({name, " data_length"}, {16'h0, data_length}, expLen);
    end
  endtask

  task automatic waitIdle(input string name);
    int cyc;
    cyc = 0;
    while (busy && cyc < 40) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      cyc++;
    end
    if (busy) begin
      nVec++;
      nFail++;
      $display("[TB] FAIL %s idle timeout: got busy=1, expected 0", name);
    end
  endtask

  initial begin
    logic [31:0] ov [0:8];

    vecs[0] = '{1'b1, 32'h11223344, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[1] = '{1'b1, 32'h55667788, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[2] = '{1'b1, 32'h99AABBCC, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[3] = '{1'b1, 32'hDDEEFF00, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[4] = '{1'b1, 32'hA0A1A2A3, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[5] = '{1'b1, 32'hB0B1B2B3, 1'b0, 1'b1, 1'b1, 16'(HDR + 16)};
    vecs[6] = '{1'b1, 32'hC0C1C2C3, 1'b0, 1'b0, 1'b1, 16'(HDR + 16)};
    vecs[7] = '{1'b1, 32'hD0D1D2D3, 1'b0, 1'b0, 1'b1, 16'(HDR + 16)};

    sample_valid  = 1'b0;
    sample_data   = 32'h0;
    flush         = 1'b0;
    payload_req_i = 1'b0;
    tx_done       = 1'b0;
    reset_n       = 1'b0;
    repeat (2) @(negedge clk125m);
    #1;
    checkOutput("reset tx_en_pulse", {31'h0, tx_en_pulse}, 32'h0);
    checkOutput("reset data_length", {16'h0, data_length}, 32'h0);
    checkOutput("reset payload_dat_o", {24'h0, payload_dat_o}, 32'h0);
    checkOutput("reset busy", {31'h0, busy}, 32'h0);
    checkOutput("reset overflow", {31'h0, overflow}, 32'h0);
    checkOutput("reset drop_cnt", {16'h0, drop_cnt}, 32'h0);
    @(negedge clk125m);
    reset_n = 1'b1;

    // Fill bank 0, then bank 1 while frame 1 is starting.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].sv, vecs[i].sd, vecs[i].fl, 1'b0, 1'b0);
      checkOutput($sformatf("vec %0d tx_en_pulse", i), {31'h0, tx_en_pulse}, {31'h0, vecs[i].expTx});
      checkOutput($sformatf("vec %0d busy", i), {31'h0, busy}, {31'h0, vecs[i].expBusy});
      checkOutput($sformatf("vec %0d data_length", i), {16'h0, data_length}, {16'h0, vecs[i].expLen});
    end
    frameWords = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
    sendPayload("frame1", 4, 32'd0, 0);
    waitStart("frame2", IFG_WAIT + 2, HDR + 16);
    frameWords = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3};
    sendPayload("frame2", 4, 32'd1, 3);
    waitIdle("frame2");

    // Partial bank closed by flush, with the coinciding sample included.
    applyStimulus(1'b1, 32'h01020304, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h05060708, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h090A0B0C, 1'b1, 1'b0, 1'b0);
    waitStart("flush", 2, HDR + 12);
    frameWords = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0};
    sendPayload("frame3", 3, 32'd2, 0);
    waitIdle("frame3");

    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("empty flush %0d tx_en_pulse", i), {31'h0, tx_en_pulse}, 32'h0);
      checkOutput($sformatf("empty flush %0d busy", i), {31'h0, busy}, 32'h0);
    end

    // Nine samples with tx_done held off: both banks fill and the ninth is lost.
    for (int i = 0; i < 9; i++) ov[i] = 32'hF0000000 + 32'(i * 32'h01010101);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, ov[i], 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("ovf write %0d tx_en_pulse", i), {31'h0, tx_en_pulse}, {31'h0, (i == 5)});
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf overflow", {31'h0, overflow}, 32'h1);
    checkOutput("ovf drop_cnt", {16'h0, drop_cnt}, 32'h1);
    checkOutput("ovf data_length", {16'h0, data_length}, HDR + 16);
    frameWords = '{ov[0], ov[1], ov[2], ov[3]};
    sendPayload("frame4", 4, 32'd3, 0);
    waitStart("frame5", IFG_WAIT + 2, HDR + 16);
    frameWords = '{ov[4], ov[5], ov[6], ov[7]};
    sendPayload("frame5", 4, 32'd4, 0);
    waitIdle("frame5");
    checkOutput("ovf sticky", {31'h0, overflow}, 32'h1);

    // Reset in the middle of SEND, then a clean frame with seq back at 0.
    frameWords = '{32'h13572468, 32'h24681357, 32'hCAFEBABE, 32'hDEADBEEF};
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, frameWords[i], 1'b0, 1'b0, 1'b0);
    waitStart("pre-reset", 2, HDR + 16);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("pre-reset byte %0d", k), {24'h0, payload_dat_o}, {24'h0, expByte(k, HDR + 16, 32'd5)});
    end
    @(negedge clk125m);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset tx_en_pulse", {31'h0, tx_en_pulse}, 32'h0);
    checkOutput("midreset data_length", {16'h0, data_length}, 32'h0);
    checkOutput("midreset payload_dat_o", {24'h0, payload_dat_o}, 32'h0);
    checkOutput("midreset busy", {31'h0, busy}, 32'h0);
    checkOutput("midreset overflow", {31'h0, overflow}, 32'h0);
    checkOutput("midreset drop_cnt", {16'h0, drop_cnt}, 32'h0);
    @(negedge clk125m);
    payload_req_i = 1'b0;
    reset_n       = 1'b1;
    frameWords = '{32'h0A0B0C0D, 32'h1A1B1C1D, 32'h2A2B2C2D, 32'h3A3B3C3D};
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, frameWords[i], 1'b0, 1'b0, 1'b0);
    waitStart("post-reset", 2, HDR + 16);
    sendPayload("post-reset", 4, 32'd0, 0);
    waitIdle("post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule

// File: doc/udp_payload_packer.md
Name: udp_payload_packer

Overview:
- Upstream feeder for the GMII UDP transmitter.
- Packs 32-bit FBG sample words into a two-bank (ping-pong) buffer.
- When a bank is full or flushed, starts one UDP frame via tx_en_pulse with the matching data_length.
- Streams payload bytes on the transmitter's payload request. Enforces the transmitter's post-frame dead time before starting the next frame.

Parameters:
PKT_WORDS, 256, sample words per full bank (1..2^ADDR_W); full frame payload = 4*PKT_WORDS (+4 with header).
ADDR_W, 8, word-index width per bank; 2^ADDR_W >= PKT_WORDS.
IFG_WAIT, 16, idle cycles after tx_done before the next tx_en_pulse; must be >= 12.

Ports:
clk125m  in  1  system clock, 125 MHz
reset_n  in  1  asynchronous active-low reset
sample_valid  in  1  sample_data valid this cycle
sample_data  in  32  sample word, transmitted big-endian
flush  in  1  pulse: close the current partial bank
tx_en_pulse  out  1  one-cycle frame start to the transmitter
data_length  out  16  UDP payload bytes; valid from tx_en_pulse until tx_done
payload_req_i  in  1  transmitter byte request, high for data_length consecutive cycles
payload_dat_o  out  8  payload byte; valid in the same cycle payload_req_i is high
tx_done  in  1  one-cycle end-of-frame from the transmitter
busy  out  1  high in START/SEND/GAP
overflow  out  1  sticky: a sample was dropped
drop_cnt  out  16  dropped-sample count, saturating at 0xFFFF

Behaviour:
- Reset (async, reset_n=0) clears:
  - tx_en_pulse=0, data_length=0, payload_dat_o=0x00, busy=0, overflow=0, drop_cnt=0.
  - Bank full flags=0, word counts=0, wbank=rbank=0, seq=0, FSM=IDLE.
- Reset mid-frame aborts: the partial frame is lost and no tx_en_pulse is issued until the FSM restarts from IDLE.
- Write side:
  - Sample is written to bank wbank at index count[wbank]; count increments.
  - When count reaches PKT_WORDS: full[wbank]=1, wbank toggles.
  - If full[wbank]=1 when sample_valid arrives: sample is dropped, overflow=1, drop_cnt increments (saturating).
  - Write sees full flags as registered at the start of the cycle. A release in the same cycle does not save the sample.
- flush:
  - If count[wbank]>0 and the bank is not full: full[wbank]=1, wbank toggles.
  - If sample_valid coincides with flush, the sample is written first and counted in the flushed bank.
  - flush on an empty bank has no effect.
- Transmit FSM, states IDLE, START, SEND, GAP:
  - IDLE: if full[rbank] -> register data_length = HDR + 4*count[rbank] (HDR = 4 with the feature, else 0), clear byte pointer, go START.
  - START: tx_en_pulse=1 for exactly this cycle; data_length is already stable in this cycle. Go SEND.
  - SEND: each cycle payload_req_i=1, the byte pointer advances by 1 after the cycle.
    - payload_dat_o is combinational from the pointer and the bank contents, so no read latency is visible. A synchronous RAM must be prefetched.
    - Byte k (after header): word (k-HDR)>>2, byte lane 3-((k-HDR)&3), MSB first.
    - Requests beyond data_length bytes return 0x00; the pointer saturates.
    - On tx_done: full[rbank]=0, count[rbank]=0, rbank toggles, seq increments (wraps 0xFFFFFFFF->0), go GAP.
  - GAP: count IFG_WAIT cycles from tx_done, then IDLE.
  - Outside SEND: payload_dat_o=0x00.
- tx_done outside SEND is ignored.
- Latency:
  - Bank filled -> tx_en_pulse 2 cycles later if IDLE.
  - tx_done -> earliest next tx_en_pulse at IFG_WAIT+2 cycles.
- Throughput: the write side may fill the other bank while the current one transmits; loss occurs only when both banks are full.

Optional Feature:
Macro PKT_SEQ_HDR_EN.
- Defined: each frame begins with a 4-byte header = seq[31:24..7:0], big-endian; data_length = 4 + 4*count.
- Undefined: no header; data_length = 4*count; seq is not implemented.

Test Plan:
1. PKT_WORDS=4, header on; write 0x11223344,0x55667788,0x99AABBCC,0xDDEEFF00 -> tx_en_pulse 2 cycles after the 4th write, data_length=20; bytes 00 00 00 00 11 22 33 44 … FF 00 over 20 req cycles.
2. After tx_done, bank already full -> no tx_en_pulse for 16 cycles; second frame header 00 00 00 01.
3. Write 2 words, pulse flush with a 3rd sample_valid in the same cycle -> data_length=16 (header on) / 12 (header off), 3 words sent.
4. Hold tx_done low; push 9 words at PKT_WORDS=4 -> 9th dropped, overflow=1, drop_cnt=1; both banks sent in order after release.
5. Assert reset_n=0 mid-SEND -> all outputs 0 next edge; after release plus 4 writes, frame seq restarts at 0.
6. Request 3 extra payload_req_i cycles past data_length -> payload_dat_o=0x00 on each; next frame starts correctly.
